// File: rtl/mdu_pkg.sv
// mdu_pkg: shared CPU constants for the multiply/divide unit
package mdu_pkg;
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_e;
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;
  localparam logic HILO_LO = 1'b0;
  localparam logic HILO_HI = 1'b1;
  // Full {HI, LO} result; a zero divisor returns the current HI/LO so they stay unchanged
  function automatic logic [63:0] md_result(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                                            input logic [63:0] hilo);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0] q;
    logic [31:0] r;
    sa = a;
    sb = b;
    q = '0;
    r = '0;
    if (op == OP_MULT) return {{32{a[31]}}, a} * {{32{b[31]}}, b};
    if (op == OP_MULTU) return {32'd0, a} * {32'd0, b};
    if (b == 32'd0) return hilo;
    if (op == OP_DIVU) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    q = sa / sb;
    r = sa % sb;
    return {r, q};
  endfunction
endpackage

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit owning the HI/LO registers
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic        hilo_we,
  input  logic        hilo_sel,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        md_hold,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  md_state_e r_state;
  md_state_e w_state_nx;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nx;
  logic [63:0] r_pend;
  logic [63:0] w_res;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic w_issue;
  logic w_commit;
  logic w_mt;
  assign w_res = md_result(md_op_e'(md_op), rs_val, rt_val, {r_hi, r_lo});
  // Next state: issue loads the countdown, the 1->0 step commits; inputs are ignored while running
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx = r_cnt;
    w_issue = 1'b0;
    w_commit = 1'b0;
    w_mt = 1'b0;
    if (r_state == ST_IDLE) begin
      w_issue = start;
      w_mt = hilo_we & ~start;
      if (start) begin
        w_state_nx = ST_RUN;
        w_cnt_nx = md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end
    end else begin
      w_cnt_nx = r_cnt - CW'(1);
      w_commit = (r_cnt == CW'(1));
      if (w_commit) w_state_nx = ST_IDLE;
    end
  end
  // State, countdown, pending result and architectural HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt <= '0;
      r_pend <= '0;
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt <= w_cnt_nx;
      if (w_issue) r_pend <= w_res;
      if (w_commit) {r_hi, r_lo} <= r_pend;
      else if (w_mt && hilo_sel == HILO_HI) r_hi <= rs_val;
      else if (w_mt && hilo_sel == HILO_LO) r_lo <= rs_val;
    end
  end
  assign busy = (r_state == ST_RUN);
  assign md_hold = start | busy;
  assign hi = r_hi;
  assign lo = r_lo;
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed self-checking bench for mdu
module tb_mdu;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [1:0] md_op = 2'b00;
  logic hilo_we = 1'b0;
  logic hilo_sel = 1'b0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic busy;
  logic md_hold;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] eh = '0;
  logic [31:0] el = '0;
  int n_chk = 0;
  int n_pass = 0;

  mdu dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .hilo_we(hilo_we), .hilo_sel(hilo_sel),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .md_hold(md_hold), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Issue one op, poke start/hilo_we once while busy (must be ignored), count busy cycles, check result
  task automatic op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                    input int n, input logic [31:0] xh, input logic [31:0] xl, input logic we);
    int cnt;
    @(negedge clk);
    start = 1'b1; md_op = o; rs_val = a; rt_val = b; hilo_we = we; hilo_sel = 1'b0;
    #1 chk({tag, " hold"}, md_hold, 1);
    @(negedge clk);
    chk({tag, " busy"}, busy, 1);
    chk({tag, " hi early"}, hi, eh);
    chk({tag, " lo early"}, lo, el);
    start = 1'b1; hilo_we = 1'b1; md_op = 2'b01; rs_val = 32'hDEAD_BEEF; rt_val = 32'd7;
    cnt = 1;
    @(negedge clk);
    start = 1'b0; hilo_we = 1'b0;
    while (busy && cnt < 60) begin
      cnt++;
      @(negedge clk);
    end
    chk({tag, " cycles"}, cnt, n);
    chk({tag, " hi"}, hi, xh);
    chk({tag, " lo"}, lo, xl);
    eh = xh;
    el = xl;
  endtask

  task automatic mt(input logic sel, input logic [31:0] v);
    @(negedge clk);
    hilo_we = 1'b1; hilo_sel = sel; rs_val = v;
    @(negedge clk);
    hilo_we = 1'b0;
    if (sel) eh = v;
    else el = v;
    chk("mt hi", hi, eh);
    chk("mt lo", lo, el);
    chk("mt busy", busy, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst busy", busy, 0);
    chk("rst hold", md_hold, 0);
    chk("rst hi", hi, 0);
    chk("rst lo", lo, 0);
    op("mult -2*3", 2'b00, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    op("multu", 2'b01, 32'hFFFF_FFFF, 32'd2, 5, 32'h1, 32'hFFFF_FFFE, 1'b0);
    op("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    op("div 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD, 1'b0);
    op("mult min*min", 2'b00, 32'h8000_0000, 32'h8000_0000, 5, 32'h4000_0000, 32'h0, 1'b0);
    op("divu 100/7", 2'b11, 32'd100, 32'd7, 10, 32'd2, 32'd14, 1'b0);
    op("div ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000, 1'b0);
    mt(1'b1, 32'h11);
    mt(1'b0, 32'h22);
    op("divu by 0", 2'b11, 32'd55, 32'd0, 10, 32'h11, 32'h22, 1'b0);
    op("div by 0", 2'b10, 32'hFFFF_FFF0, 32'd0, 10, 32'h11, 32'h22, 1'b0);
    mt(1'b1, 32'hABCD);
    op("start+we", 2'b01, 32'd3, 32'd5, 5, 32'h0, 32'd15, 1'b1);
    @(negedge clk);
    start = 1'b1; md_op = 2'b00; rs_val = 32'd5; rt_val = 32'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort busy", busy, 0);
    chk("abort hi", hi, 0);
    chk("abort lo", lo, 0);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("no commit busy", busy, 0);
    chk("no commit hi", hi, 0);
    chk("no commit lo", lo, 0);
    eh = '0;
    el = '0;
    reset = 1'b1; start = 1'b1; hilo_we = 1'b1; hilo_sel = 1'b1; rs_val = 32'h55; rt_val = 32'd3;
    @(negedge clk);
    reset = 1'b0; start = 1'b0; hilo_we = 1'b0;
    chk("rst prio busy", busy, 0);
    chk("rst prio hi", hi, 0);
    @(negedge clk);
    chk("rst prio idle", busy, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
